// File: rtl/core_mc_rv32.sv
// core_mc_rv32: multi-cycle RV32I/RV32E core with one shared req/ready memory port and a sticky trap
// clk, resetn (sync, active-low); address/data_out/we/mem_req out, data_in/mem_ready in;
// retired pulses on commit; trap/trap_cause report the halting fault.
module core_mc_rv32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] address,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  output logic        we,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic        retired,
  output logic        trap,
  output logic [1:0]  trap_cause
);
  localparam int AW = (NREGS == 16) ? 4 : 5;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic req_en_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, res_q, tgt_q;
  logic jmp_q;
  logic [31:0] rf_q [NREGS];
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, mem_op;
  logic legal, bad_reg, use_rd, use_rs1, use_rs2;
  logic [31:0] imm, op2, sum, alu, tgt, res;
  logic lt, ltu, taken, jump, hs, ea_bad, tg_bad;
  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];
  assign is_lui   = opc == 7'h37;
  assign is_auipc = opc == 7'h17;
  assign is_jal   = opc == 7'h6f;
  assign is_jalr  = opc == 7'h67;
  assign is_br    = opc == 7'h63;
  assign is_ld    = opc == 7'h03;
  assign is_st    = opc == 7'h23;
  assign is_opi   = opc == 7'h13;
  assign is_op    = opc == 7'h33;
  assign mem_op   = is_ld || is_st;
  assign legal = is_lui || is_auipc || is_jal || (is_jalr && f3 == 3'd0)
              || (is_br && f3[2:1] != 2'b01) || (mem_op && f3 == 3'd2)
              || (is_opi && ((f3 == 3'd1) ? f7 == 7'h00 : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1))
              || (is_op && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))));
  // only fields the instruction actually uses are register indices; the rest are immediate bits
  assign use_rd  = is_lui || is_auipc || is_jal || is_jalr || is_ld || is_opi || is_op;
  assign use_rs1 = is_jalr || is_br || mem_op || is_opi || is_op;
  assign use_rs2 = is_br || is_st || is_op;
  assign bad_reg = (NREGS < 32) && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]));
  assign imm = (is_lui || is_auipc) ? {ir_q[31:12], 12'b0}
             : is_jal ? {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}
             : is_br  ? {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}
             : is_st  ? {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]}
             : {{20{ir_q[31]}}, ir_q[31:20]};
  assign op2   = (is_op || is_br) ? b_q : imm_q;
  assign sum   = a_q + imm_q;
  assign lt    = $signed(a_q) < $signed(op2);
  assign ltu   = a_q < op2;
  assign taken = (f3[2] ? (f3[1] ? ltu : lt) : (a_q == b_q)) ^ f3[0];
  assign jump  = is_jal || is_jalr || (is_br && taken);
  assign tgt   = is_jalr ? {sum[31:1], 1'b0} : pc_q + imm_q;
  always_comb begin
    case (f3)
      3'd0:    alu = (is_op && ir_q[30]) ? a_q - op2 : a_q + op2;
      3'd1:    alu = a_q << op2[4:0];
      3'd2:    alu = {31'b0, lt};
      3'd3:    alu = {31'b0, ltu};
      3'd4:    alu = a_q ^ op2;
      3'd5:    alu = ir_q[30] ? $unsigned($signed(a_q) >>> op2[4:0]) : a_q >> op2[4:0];
      3'd6:    alu = a_q | op2;
      default: alu = a_q & op2;
    endcase
  end
  assign res = is_lui ? imm_q : is_auipc ? pc_q + imm_q : (is_jal || is_jalr) ? pc_q + 32'd4 : mem_op ? sum : alu;
  assign hs     = mem_req && mem_ready;
  assign ea_bad = mem_op && sum[1:0] != 2'b00;
  assign tg_bad = jump && tgt[1:0] != 2'b00;
  // req_en_q keeps mem_req low for the first cycle after reset so a late mem_ready is dropped
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= FETCH;
      cause_q  <= 2'd0;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      req_en_q <= 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      FETCH:  state_d = hs ? DECODE : FETCH;
      DECODE: begin
        state_d = (legal && !bad_reg) ? EXEC : TRAP;
        cause_d = !legal ? 2'd0 : bad_reg ? 2'd3 : cause_q;
      end
      EXEC: begin
        state_d = (ea_bad || tg_bad) ? TRAP : mem_op ? MEM : WB;
        cause_d = ea_bad ? 2'd1 : tg_bad ? 2'd2 : cause_q;
      end
      MEM:     state_d = !hs ? MEM : is_st ? FETCH : WB;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end
  always_comb begin
    mem_req    = req_en_q && (state_q == FETCH || state_q == MEM);
    we         = state_q == MEM && is_st;
    address    = (state_q == MEM) ? res_q : pc_q;
    data_out   = we ? b_q : 32'd0;
    retired    = state_q == WB || (state_q == MEM && is_st && hs);
    trap       = state_q == TRAP;
    trap_cause = cause_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      res_q <= '0;
      tgt_q <= '0;
      jmp_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        FETCH: if (hs) ir_q <= data_in;
        DECODE: begin
          a_q   <= rf_q[rs1[AW-1:0]];
          b_q   <= rf_q[rs2[AW-1:0]];
          imm_q <= imm;
        end
        EXEC: begin
          res_q <= res;
          tgt_q <= tgt;
          jmp_q <= jump;
        end
        MEM: if (hs) begin
          if (is_st) pc_q <= pc_q + 32'd4;
          else res_q <= data_in;
        end
        WB: begin
          if (use_rd && rd != 5'd0) rf_q[rd[AW-1:0]] <= res_q;
          pc_q <= jmp_q ? tgt_q : pc_q + 32'd4;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_core_mc_rv32.sv
// tb_core_mc_rv32: directed programs against core_mc_rv32 with a bus-transaction scoreboard
module tb_core_mc_rv32;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [31:0] address, data_out;
  logic [31:0] data_in = '0;
  logic we, mem_req, retired, trap;
  logic mem_ready = 1'b0;
  logic [1:0] trap_cause;
  core_mc_rv32 #(.RESET_PC(32'h100), .NREGS(16)) dut (
    .clk(clk), .resetn(resetn), .address(address), .data_out(data_out), .data_in(data_in),
    .we(we), .mem_req(mem_req), .mem_ready(mem_ready), .retired(retired),
    .trap(trap), .trap_cause(trap_cause)
  );
  always #5 clk = ~clk;
  typedef struct { logic w; logic [31:0] a; logic [31:0] d; } txn_t;
  txn_t sb[$];
  int ret_q[$];
  int checks = 0, failures = 0, cyc = 0, waits = 0, wcnt = 0;
  logic stray = 1'b0;
  logic [31:0] mem [0:255];
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] opc);
    logic [31:0] m;
    m = imm;
    return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), opc};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm); return enc_i(imm, rs1, 0, rd, 7'h13); endfunction
  function automatic logic [31:0] lw(int rd, int rs1, int imm); return enc_i(imm, rs1, 2, rd, 7'h03); endfunction
  function automatic logic [31:0] jalr(int rd, int rs1, int imm); return enc_i(imm, rs1, 0, rd, 7'h67); endfunction
  function automatic logic [31:0] rtype(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] sw(int rs2, int rs1, int imm);
    logic [31:0] m;
    m = imm;
    return {m[11:5], 5'(rs2), 5'(rs1), 3'd2, m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] br(int f3, int rs1, int rs2, int imm);
    logic [31:0] m;
    m = imm;
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
  endfunction
  function automatic logic [31:0] jal(int rd, int imm);
    logic [31:0] m;
    m = imm;
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6f};
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic put(logic [31:0] a, logic [31:0] w); mem[a[9:2]] = w; endtask
  task automatic pf(logic [31:0] a); sb.push_back('{1'b0, a, 32'h0}); endtask
  task automatic ps(logic [31:0] a, logic [31:0] d); sb.push_back('{1'b1, a, d}); endtask
  task automatic pl(logic [31:0] a); sb.push_back('{1'b0, a, 32'h0}); endtask
  task automatic hold_reset(string tag);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    ret_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    chk({tag, "_rst_addr"}, address, 32'h100);
    chk({tag, "_rst_dout"}, data_out, 32'h0);
    chk({tag, "_rst_we"}, we, 0);
    chk({tag, "_rst_req"}, mem_req, 0);
    chk({tag, "_rst_ret"}, retired, 0);
    chk({tag, "_rst_trap"}, trap, 0);
    chk({tag, "_rst_cause"}, trap_cause, 0);
  endtask
  task automatic run_to_trap(string tag);
    int n = 0;
    while (trap !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_trap"}, trap, 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask
  task automatic trap_case(string tag, logic [31:0] w0, logic [31:0] w1, logic [1:0] cause, logic [31:0] pc);
    hold_reset(tag);
    put(32'h100, w0);
    put(32'h104, w1);
    pf(32'h100);
    if (pc == 32'h104) pf(32'h104);
    resetn = 1'b1;
    run_to_trap(tag);
    chk({tag, "_cause"}, trap_cause, cause);
    chk({tag, "_pc"}, address, pc);
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  // memory model: answers after `waits` stalled cycles; stray forces a ready with no request
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else if (mem_req && wcnt >= waits) begin
      mem_ready = 1'b1;
      data_in = mem[address[9:2]];
      if (we) mem[address[9:2]] = data_out;
      wcnt = 0;
    end else begin
      mem_ready = stray;
      if (stray) data_in = '0;
      if (mem_req) wcnt++;
    end
  end
  initial begin
    txn_t e;
    logic pend = 1'b0, pwe = 1'b0;
    logic [31:0] pa = '0, pd = '0;
    forever begin
      @(negedge clk); #1;
      if (!resetn) pend = 1'b0;
      else begin
        if (retired) ret_q.push_back(cyc);
        if (mem_req) begin
          if (pend) begin
            chk("hold_addr", address, pa);
            chk("hold_we", we, pwe);
            chk("hold_data", data_out, pd);
          end
          pend = !mem_ready;
          pa = address;
          pwe = we;
          pd = data_out;
        end else pend = 1'b0;
        if (mem_req && mem_ready) begin
          checks++;
          assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL bus_unexpected observed=%h expected=none", address);
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("bus_addr", address, e.a);
            chk("bus_we", we, e.w);
            if (e.w) chk("bus_wdata", data_out, e.d);
          end
        end
      end
    end
  end
  initial begin
    int n;
    hold_reset("p1");
    waits = 0;
    put(32'h100, addi(1, 0, 5));
    put(32'h104, addi(2, 1, -7));
    put(32'h108, rtype(32, 2, 1, 0, 3));
    put(32'h10C, sw(1, 0, 32'h80));
    put(32'h110, sw(2, 0, 32'h84));
    put(32'h114, sw(3, 0, 32'h88));
    pf(32'h100); pf(32'h104); pf(32'h108); pf(32'h10C);
    ps(32'h80, 32'd5); pf(32'h110);
    ps(32'h84, 32'hFFFF_FFFE); pf(32'h114);
    ps(32'h88, 32'd7); pf(32'h118);
    resetn = 1'b1;
    run_to_trap("p1");
    chk("p1_cause", trap_cause, 0);
    chk("p1_pc", address, 32'h118);
    chk("p1_req_off", mem_req, 0);
    chk("p1_we_off", we, 0);
    chk("p1_ret_off", retired, 0);
    chk("p1_nret", ret_q.size(), 6);
    for (int i = 1; i < 5; i++) chk("p1_lat", ret_q[i] - ret_q[i-1], 4);
    hold_reset("p2");
    waits = 3;
    put(32'h100, addi(3, 0, 7));
    put(32'h104, sw(3, 0, 8));
    put(32'h108, lw(4, 0, 8));
    put(32'h10C, sw(4, 0, 32'h80));
    pf(32'h100); pf(32'h104); ps(32'h8, 32'd7); pf(32'h108); pl(32'h8);
    pf(32'h10C); ps(32'h80, 32'd7); pf(32'h110);
    resetn = 1'b1;
    run_to_trap("p2");
    chk("p2_mem8", mem[2], 32'd7);
    chk("p2_lat_sw", ret_q[1] - ret_q[0], 10);
    chk("p2_lat_lw", ret_q[2] - ret_q[1], 11);
    chk("p2_lat_sw2", ret_q[3] - ret_q[2], 10);
    hold_reset("p3");
    waits = 0;
    put(32'h100, addi(1, 0, 3));
    put(32'h104, addi(2, 2, 1));
    put(32'h108, addi(1, 1, -1));
    put(32'h10C, br(1, 1, 0, -8));
    put(32'h110, addi(3, 0, -1));
    put(32'h114, addi(4, 0, 1));
    put(32'h118, br(6, 3, 4, 8));
    put(32'h11C, br(6, 4, 3, 8));
    put(32'h120, addi(5, 0, 1));
    put(32'h124, sw(2, 0, 32'h80));
    put(32'h128, sw(5, 0, 32'h84));
    pf(32'h100);
    for (int i = 0; i < 3; i++) begin
      pf(32'h104); pf(32'h108); pf(32'h10C);
    end
    pf(32'h110); pf(32'h114); pf(32'h118); pf(32'h11C); pf(32'h124);
    ps(32'h80, 32'd3); pf(32'h128); ps(32'h84, 32'd0); pf(32'h12C);
    resetn = 1'b1;
    run_to_trap("p3");
    chk("p3_nret", ret_q.size(), 16);
    chk("p3_pc", address, 32'h12C);
    hold_reset("p4");
    put(32'h100, jal(0, -224));
    put(32'h20, jal(1, 16));
    put(32'h30, jalr(0, 1, 0));
    put(32'h24, addi(0, 0, 9));
    put(32'h28, jal(0, 20));
    put(32'h3C, sw(1, 0, 32'h80));
    put(32'h40, sw(0, 0, 32'h84));
    pf(32'h100); pf(32'h20); pf(32'h30); pf(32'h24); pf(32'h28); pf(32'h3C);
    ps(32'h80, 32'h24); pf(32'h40); ps(32'h84, 32'h0); pf(32'h44);
    resetn = 1'b1;
    run_to_trap("p4");
    chk("p4_lat_jal", ret_q[2] - ret_q[1], 4);
    chk("p4_lat_jalr", ret_q[3] - ret_q[2], 4);
    trap_case("lw_mis", lw(1, 0, 2), 32'h0, 2'd1, 32'h100);
    trap_case("reg_ge_n", rtype(0, 2, 1, 0, 20), 32'h0, 2'd3, 32'h100);
    trap_case("jalr_mis", addi(1, 0, 3), jalr(0, 1, 3), 2'd2, 32'h104);
    trap_case("bad_f7", rtype(32, 2, 1, 1, 3), 32'h0, 2'd0, 32'h100);
    trap_case("ecall", 32'h0000_0073, 32'h0, 2'd0, 32'h100);
    hold_reset("p7");
    waits = 3;
    put(32'h100, sw(0, 0, 32'h80));
    put(32'h80, 32'h5A5A_5A5A);
    pf(32'h100); pf(32'h100); ps(32'h80, 32'h0); pf(32'h104);
    resetn = 1'b1;
    n = 0;
    while (we !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("p7_in_mem", we, 1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("p7_req_drop", mem_req, 0);
    chk("p7_pc_reset", address, 32'h100);
    chk("p7_no_store", mem[32], 32'h5A5A_5A5A);
    resetn = 1'b1;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    chk("p7_fetch_req", mem_req, 1);
    chk("p7_fetch_addr", address, 32'h100);
    run_to_trap("p7");
    chk("p7_cause", trap_cause, 0);
    chk("p7_pc", address, 32'h104);
    chk("p7_store", mem[32], 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
